// File: rtl/piso_serial_ctrl.sv
// piso_serial_ctrl: parallel-in/serial-out sequencing controller.
// Accepts a word over a valid/ready handshake and shifts it out MSB-first,
// one bit per clock. Frames are marked with frame_start/frame_end strobes,
// and a programmable idle gap is inserted between frames.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each
// frame. In that build, frame_end marks the parity bit instead of the data LSB.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a word; din_ready=1 once out of reset
// S_SHIFT | emitting data bits MSB-first, bitcnt counts 0..WIDTH-1
// S_PAR   | emitting the even-parity bit (PISO_PARITY_EN builds only)
// S_GAP   | idle gap of GAP cycles, sout_valid=0, busy=1

module piso_serial_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("piso_serial_ctrl: WIDTH must be in 2..32");
  end
  if (GAP < 0 || GAP > 15) begin : g_bad_gap
    $error("piso_serial_ctrl: GAP must be in 0..15");
  end

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_PAR   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;
`endif

  // With no gap the frame returns straight to IDLE.
  localparam state_t POST_FRAME = (GAP == 0) ? S_IDLE : S_GAP;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
  // rdy_q keeps din_ready low while reset is held and goes high on the
  // first edge after release, so din_ready depends on registered state only.
  logic             rdy_q, rdy_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      rdy_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      rdy_q    <= rdy_d;
`ifdef PISO_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Next-state logic: capture, shift, parity and gap counting.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    rdy_d    = 1'b1;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (din_valid && din_ready) begin
          shreg_d  = din;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
`ifdef PISO_PARITY_EN
          par_d    = ^din;
`endif
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bitcnt_q == BIT_LAST) begin
`ifdef PISO_PARITY_EN
          state_d  = S_PAR;
`else
          state_d  = POST_FRAME;
          gapcnt_d = '0;
`endif
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        state_d  = POST_FRAME;
        gapcnt_d = '0;
      end
`endif
      S_GAP: begin
        if (gapcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only; no input reaches an output.
  always_comb begin
    din_ready   = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        din_ready = rdy_q;
      end
      S_SHIFT: begin
        sout        = shreg_q[WIDTH-1];
        sout_valid  = 1'b1;
        frame_start = (bitcnt_q == '0);
`ifndef PISO_PARITY_EN
        frame_end   = (bitcnt_q == BIT_LAST);
`endif
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        sout       = par_q;
        sout_valid = 1'b1;
        frame_end  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serial_ctrl.sv
// Directed bench for piso_serial_ctrl: three WIDTH=4 instances with GAP=1,
// GAP=0 and GAP=3. Expected output vectors are hand-computed per cycle.
// Packed observation order: {sout, sout_valid, frame_start, frame_end, busy, din_ready}.

module tb_piso_serial_ctrl;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dn [3];
  logic       dv [3];
  wire  [2:0] w_rdy, w_so, w_sv, w_fs, w_fe, w_busy;

  int n_chk = 0;
  int n_err = 0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  piso_serial_ctrl #(.WIDTH(4), .GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .din(dn[0]), .din_valid(dv[0]),
    .din_ready(w_rdy[0]), .sout(w_so[0]), .sout_valid(w_sv[0]),
    .frame_start(w_fs[0]), .frame_end(w_fe[0]), .busy(w_busy[0]));

  piso_serial_ctrl #(.WIDTH(4), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .din(dn[1]), .din_valid(dv[1]),
    .din_ready(w_rdy[1]), .sout(w_so[1]), .sout_valid(w_sv[1]),
    .frame_start(w_fs[1]), .frame_end(w_fe[1]), .busy(w_busy[1]));

  piso_serial_ctrl #(.WIDTH(4), .GAP(3)) u_g3 (
    .clk(clk), .reset(reset), .din(dn[2]), .din_valid(dv[2]),
    .din_ready(w_rdy[2]), .sout(w_so[2]), .sout_valid(w_sv[2]),
    .frame_start(w_fs[2]), .frame_end(w_fe[2]), .busy(w_busy[2]));

  function automatic logic [5:0] obs(input int i);
    return {w_so[i], w_sv[i], w_fs[i], w_fe[i], w_busy[i], w_rdy[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got[5:0], exp[5:0]);
    end
  endtask

  // Caller has just presented a word at a negedge; walk the expected queue
  // one cycle at a time. nxt replaces din after the first acceptance, and
  // din_valid drops at cycle drop_at.
  task automatic run_stream(input int inst, input string name,
                            input logic [3:0] nxt, input int drop_at);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) dn[inst] = nxt;
      if (i + 1 == drop_at) dv[inst] = 1'b0;
      chk($sformatf("%s c%0d", name, i + 1), {26'd0, obs(inst)}, {26'd0, exp_q[i]});
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dn[i] = 4'hF;
      dv[i] = 1'b1;
    end

    // Reset held three edges with din_valid high: nothing captured.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_out%0d", i), {26'd0, obs(i)}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) dv[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("post_reset%0d", i), {26'd0, obs(i)}, 32'b000001);

    // Single frame 1011, GAP=1.
    exp_q.delete();
    exp_q.push_back(6'b111010);
    exp_q.push_back(6'b010010);
    exp_q.push_back(6'b110010);
    exp_q.push_back(PAR ? 6'b110010 : 6'b110110);
    if (PAR) exp_q.push_back(6'b110110);
    exp_q.push_back(6'b000010);
    exp_q.push_back(6'b000001);
    dn[0] = 4'b1011;
    dv[0] = 1'b1;
    run_stream(0, "single", 4'b1011, 1);

    // Back-to-back A then 5, GAP=0, din_valid held.
    exp_q.delete();
    exp_q.push_back(6'b111010);
    exp_q.push_back(6'b010010);
    exp_q.push_back(6'b110010);
    exp_q.push_back(PAR ? 6'b010010 : 6'b010110);
    if (PAR) exp_q.push_back(6'b010110);
    exp_q.push_back(6'b000001);
    exp_q.push_back(6'b011010);
    exp_q.push_back(6'b110010);
    exp_q.push_back(6'b010010);
    exp_q.push_back(PAR ? 6'b110010 : 6'b110110);
    if (PAR) exp_q.push_back(6'b010110);
    exp_q.push_back(6'b000001);
    dn[1] = 4'hA;
    dv[1] = 1'b1;
    run_stream(1, "b2b", 4'h5, PAR ? 7 : 6);

    // Gap spacing 1001, GAP=3.
    exp_q.delete();
    exp_q.push_back(6'b111010);
    exp_q.push_back(6'b010010);
    exp_q.push_back(6'b010010);
    exp_q.push_back(PAR ? 6'b110010 : 6'b110110);
    if (PAR) exp_q.push_back(6'b010110);
    for (int i = 0; i < 3; i++) exp_q.push_back(6'b000010);
    exp_q.push_back(6'b000001);
    dn[2] = 4'b1001;
    dv[2] = 1'b1;
    run_stream(2, "gap3", 4'b1001, 1);

    // Reset in cycle 2 of a frame 1100, then a clean frame 0110.
    dn[0] = 4'b1100;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    chk("midrst c1", {26'd0, obs(0)}, 32'b111010);
    @(negedge clk);
    chk("midrst c2", {26'd0, obs(0)}, 32'b110010);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst abandon", {26'd0, obs(0)}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst ready", {26'd0, obs(0)}, 32'b000001);
    exp_q.delete();
    exp_q.push_back(6'b011010);
    exp_q.push_back(6'b110010);
    exp_q.push_back(6'b110010);
    exp_q.push_back(PAR ? 6'b010010 : 6'b010110);
    if (PAR) exp_q.push_back(6'b010110);
    exp_q.push_back(6'b000010);
    exp_q.push_back(6'b000001);
    dn[0] = 4'b0110;
    dv[0] = 1'b1;
    run_stream(0, "after_rst", 4'b0110, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_serial_ctrl.md
# piso_serial_ctrl

Sequencing controller for parallel-in/serial-out transmission. It accepts a parallel word through a valid/ready handshake and loads it into its internal shift stage. It then emits the word MSB-first, one bit per clock, framed by start/end strobes, and enforces a programmable idle gap between frames. It sits between a word-producing block and any single-bit serial sink, and replaces free-running shift chains that have no load/shift control.

## Interface
- `WIDTH`, default 4: word width in bits, legal 2..32.
- `GAP`, default 1: idle cycles inserted after each frame, legal 0..15.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `din` in `WIDTH`: parallel word, sampled when `din_valid && din_ready`.
- `din_valid` in 1: producer has a word.
- `din_ready` out 1: controller can accept a word this cycle.
- `sout` out 1: serial data bit.
- `sout_valid` out 1: `sout` carries a frame bit this cycle.
- `frame_start` out 1: high on the first bit of a frame.
- `frame_end` out 1: high on the last bit of a frame.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, PAR (present only with the parity option), GAP.
- IDLE:
  - `din_ready`=1.
  - On a handshake, capture `din` into `shreg` and the popcount parity, clear `bitcnt`, and go to SHIFT.
  - No handshake: stay in IDLE.
- SHIFT:
  - `sout`=`shreg[WIDTH-1]` and `sout_valid`=1.
  - Each cycle, shift `shreg` left by one (zero fill) and increment `bitcnt`.
  - `frame_start`=1 when `bitcnt`==0.
  - When `bitcnt`==`WIDTH-1`:
    - without parity: `frame_end`=1, next state is GAP (or IDLE if `GAP`==0);
    - with parity: next state is PAR.
- PAR:
  - `sout`=even-parity bit, i.e. XOR of the captured word.
  - `sout_valid`=1 and `frame_end`=1 for one cycle.
  - Next state is GAP (or IDLE if `GAP`==0).
- GAP:
  - `sout_valid`=0 and `sout`=0.
  - A gap counter counts `GAP` cycles, then the FSM returns to IDLE.
- `din_ready` is 0 in every state except IDLE. `din_valid` outside IDLE is ignored, and the word is held by the producer.
- `bitcnt` width is `$clog2(WIDTH)`. The gap counter is 4 bits. Neither counter wraps: each is cleared on entry to its state.
- `WIDTH`==2 and `GAP`==0 are legal with no special casing. With `GAP`==0 the FSM goes from the last bit directly to IDLE.

## Timing
- All outputs are registered combinational decodes of state/`shreg`/`bitcnt`; there are no input-to-output combinational paths except none: `din_ready` depends only on state.
- Handshake at edge E:
  - first bit (MSB) is valid in the cycle after E;
  - last data bit follows `WIDTH` cycles after E;
  - parity bit, if enabled, follows at E+`WIDTH`+1.
- Frame period (handshake to next possible handshake) = 1 + `WIDTH` + P + `GAP` cycles, where P=1 if parity is enabled, else 0.
- Reset values, forced at the first edge with `reset`=0:
  - state=IDLE, `shreg`=0, counters=0;
  - `sout`=0, `sout_valid`=0, `frame_start`=0, `frame_end`=0, `busy`=0, `din_ready`=0 while `reset` is low.
  - `din_ready` becomes 1 in the first cycle after `reset` deasserts.
- Reset mid-frame: the frame is abandoned at that edge and no `frame_end` is emitted. A `din_valid` coincident with reset low is not accepted.
- `din_valid` held continuously: words are accepted back-to-back, one per frame period, with no loss and no duplication.

## Configuration
- `PISO_PARITY_EN`:
  - Defined: PAR state is compiled in and one even-parity bit is appended to each frame. `frame_end` marks the parity bit. Frame length is `WIDTH`+1.
  - Undefined: no PAR state and no parity logic. `frame_end` marks the data LSB. Frame length is `WIDTH`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `din_valid`=1 → all outputs 0, no capture; first cycle after release shows `din_ready`=1.
- **Single frame:** `WIDTH`=4, `GAP`=1, `din`=4'b1011 accepted at cycle 0 →
  - `sout` is 1,0,1,1 in cycles 1–4 with `sout_valid`=1;
  - `frame_start` in cycle 1, `frame_end` in cycle 4;
  - gap in cycle 5, `din_ready`=1 in cycle 6.
- **Parity:** with `PISO_PARITY_EN`, same stimulus → parity bit `sout`=1 in cycle 5 with `frame_end`; no `frame_end` in cycle 4.
- **Back-to-back:** `GAP`=0, `din_valid` held, words 4'hA then 4'h5 → serial stream 1010 then 0101, second `frame_start` 5 cycles after the first, `din_ready` low during shifting.
- **Reset mid-frame:** `reset`=0 in cycle 2 of a frame → next cycle `sout_valid`=0, `busy`=0, no `frame_end`; the following word shifts out cleanly from MSB.
- **Gap spacing:** `GAP`=3 → exactly 3 cycles with `sout_valid`=0 and `busy`=1 between `frame_end` and the next IDLE.
